spi_frame_loader: RTL and testbench
===================================

# spi_frame_loader

Parametrised SPI command decoder for the display controller. It receives framed byte streams from the SPI slave and unpacks row-addressed pixel data into words for the frame-buffer write port. It also handles a brightness command and a buffer commit handshake. Compared with the previous loader it adds:
- an explicit row address;
- true per-channel packing of `wdata`;
- a configurable channel count;
- overflow and short-frame detection;
- an optional checksum.

## Interface
Parameters:
- `SEGMENTS`, 1: pixel words packed per `wdata` write.
- `CHANNELS`, 3: colour channels per pixel.
- `BITWIDTH`, 8: bits per channel, 1..8. Each channel byte uses its low `BITWIDTH` bits.
- `ROWS`, 8: addressable rows.
- `COLUMNS`, 32: `wdata` writes per row.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset. Synchronous, active-high.
- `sclk`, `ss`, `mosi`  in  1: SPI bus.
- `miso`  out  1: SPI return line, driven by the sub-module.
- `ready`  in  1: frame buffer may accept a new frame.
- `wen`  out  1: one-cycle write strobe.
- `wrow`  out  `$clog2(ROWS)`: write row.
- `wcol`  out  `$clog2(COLUMNS)`: write column.
- `wdata`  out  `SEGMENTS*CHANNELS*BITWIDTH`: packed write word.
- `brightness`  out  8: global brightness.
- `loaded`  out  1: one-cycle pulse when a commit is accepted.
- `frame_err`  out  1: one-cycle pulse on a malformed frame.

## Operation
- Byte stream comes from the sub-module: `data`, `valid`, `sot` (first byte of a transaction), `eot` (`ss` deasserted).
- The command byte is the byte with `sot` and `valid` both high. It is accepted only in `IDLE` with `ready` high.
  - Not ready: go to `DISCARD`; no error.
  - Unknown opcode: go to `DISCARD` and pulse `frame_err`.

Commands:
- `8'hF0` LOAD_ROW → `ROW_ADDR`. Next byte is the row index.
  - Index ≥ `ROWS`: pulse `frame_err`, go to `DISCARD`.
  - Otherwise latch the index into `wrow` and go to `PIXELS`.
- `8'h20` SET_BRIGHT → `BRIGHT`. Next byte is loaded into `brightness`; then `DISCARD`.
- `8'h10` COMMIT → `COMMIT`. On `eot`, pulse `loaded`, then `IDLE`.

In `PIXELS`:
- Each valid byte shifts into a staging register.
- The first byte of a group lands in the most-significant `BITWIDTH` slot of `wdata`. Order is segment-major, then channel (R, G, B).
- After `SEGMENTS*CHANNELS` bytes: `wdata` ← staging, `wen` pulses, `wcol` = column index, and the column counter increments.
- After `COLUMNS` writes: go to `DISCARD` (no checksum) or `CHECK` (checksum on).
- Extra bytes are ignored and pulse `frame_err` once.

Termination rules:
- `eot` in any state returns the block to `IDLE`.
- `eot` in `ROW_ADDR`, `BRIGHT` or `PIXELS` is a short frame: pulse `frame_err`. Completed column writes stand; the partial group is dropped.
- `DISCARD` ignores bytes until `eot`.

Widths and counters:
- Column counter and group counter saturate at their terminal values; they never wrap mid-frame.

## Timing
Reset values:
- `wen`, `loaded`, `frame_err`, `wrow`, `wcol`, `wdata` = 0.
- `brightness` = 8'hFF.
- State = `IDLE`; all counters 0.
- Reset mid-frame aborts immediately. No `wen` or `loaded` is issued afterwards until a new `sot`.

Latencies:
- `wen`/`wcol`/`wdata` are registered, one cycle after the `valid` of the group's last byte.
- `wen` is high for exactly one cycle.
- `loaded` fires one cycle after `eot` of a COMMIT frame.
- `frame_err` fires one cycle after the offending byte or `eot`.
- `brightness` updates one cycle after its data byte.

Ordering and sampling:
- `valid` and `eot` in the same cycle: the byte is processed first, then the frame terminates.
- `ready` is sampled only at the command byte. Dropping `ready` mid-frame does not stop writes.

## Configuration
- `SPI_LOADER_CHECKSUM_EN` defined:
  - LOAD_ROW frames carry one trailing byte equal to the XOR of the row byte and all pixel bytes.
  - In `CHECK`, a mismatch pulses `frame_err` and sets a `dirty` flag.
  - A COMMIT while `dirty` is set does not pulse `loaded`; it clears `dirty` instead.
  - `eot` before the checksum byte is a short frame and also sets `dirty`.
- Undefined: no `CHECK` state, no `dirty` flag; `loaded` always fires on COMMIT.

## Structure
Shared package `display_pkg`:
- Opcode constants `OP_LOAD_ROW`, `OP_COMMIT`, `OP_BRIGHT`.
- State enum: `IDLE`, `ROW_ADDR`, `PIXELS`, `CHECK`, `BRIGHT`, `COMMIT`, `DISCARD`.
- `BRIGHT_RESET` constant.

Sub-module: the existing `spi_slave`, instantiated once. It provides `data`/`valid`/`sot`/`eot` and drives `miso`. No other sub-modules.

## Test plan
All scenarios use default parameters.
- F0, 03, then 96 bytes 00..5F, `eot` → 32 `wen` pulses, `wrow` = 3, `wcol` 0..31. First `wdata` = 24'h000102, last = 24'h5D5E5F. No `frame_err`.
- F0, 09 → `frame_err` pulse, zero `wen`, state `IDLE` after `eot`.
- F0, 00, then 7 bytes, `eot` → 2 `wen` pulses (`wcol` 0, 1), one `frame_err`, next frame accepted normally.
- 20, 40 → `brightness` = 8'h40. Then 10 with `ready` = 0 → no `loaded`. Then 10 with `ready` = 1 → one `loaded` pulse after `eot`.
- `rst` asserted after 10 pixel bytes → all outputs at reset values, `brightness` = FF. A following full LOAD_ROW succeeds.
- Checksum enabled: full row frame with a wrong checksum byte, then COMMIT → one `frame_err`, no `loaded`. A second COMMIT → `loaded` pulses.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the display controller: SPI opcodes, the frame
// loader state encoding and the brightness reset level.
package display_pkg;

    localparam logic [7:0] OP_LOAD_ROW  = 8'hF0;
    localparam logic [7:0] OP_COMMIT    = 8'h10;
    localparam logic [7:0] OP_BRIGHT    = 8'h20;
    localparam logic [7:0] BRIGHT_RESET = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        ROW_ADDR,
        PIXELS,
        CHECK,
        BRIGHT,
        COMMIT,
        DISCARD
    } state_t;

endpackage

// File: rtl/spi_slave.sv
// SPI mode-0 byte receiver. Bus lines are synchronised into clk, bytes are
// assembled MSB first on sclk rising edges and presented as one-cycle
// valid pulses; sot tags the first byte after ss falls, eot pulses when ss
// rises. miso echoes the previously received byte.
module spi_slave (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       ss,
    input  logic       mosi,
    output logic       miso,
    output logic [7:0] data,
    output logic       valid,
    output logic       sot,
    output logic       eot
);

    logic [2:0] sclk_sync_reg;
    logic [2:0] ss_sync_reg;
    logic [1:0] mosi_sync_reg;
    logic [7:0] shift_reg;
    logic [7:0] tx_reg;
    logic [2:0] bit_cnt_reg;
    logic       first_reg;
    logic [7:0] data_reg;
    logic       valid_reg;
    logic       sot_reg;
    logic       eot_reg;

    logic sclk_rise, sclk_fall, ss_active, ss_fall, ss_rise, mosi_s;
    logic [7:0] shift_in;

    assign sclk_rise = sclk_sync_reg[1] & ~sclk_sync_reg[2];
    assign sclk_fall = ~sclk_sync_reg[1] & sclk_sync_reg[2];
    assign ss_active = ~ss_sync_reg[1];
    assign ss_fall   = ~ss_sync_reg[1] & ss_sync_reg[2];
    assign ss_rise   = ss_sync_reg[1] & ~ss_sync_reg[2];
    assign mosi_s    = mosi_sync_reg[1];
    assign shift_in  = {shift_reg[6:0], mosi_s};

    // Bus synchronisers. ss resets to "selected" so that a reset taken in the
    // middle of a transaction never fakes a start-of-transaction edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_reg <= 3'b000;
            ss_sync_reg   <= 3'b000;
            mosi_sync_reg <= 2'b00;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[1:0], sclk};
            ss_sync_reg   <= {ss_sync_reg[1:0], ss};
            mosi_sync_reg <= {mosi_sync_reg[0], mosi};
        end
    end

    // Byte assembly, framing flags and miso echo shifter.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg   <= 8'd0;
            tx_reg      <= 8'd0;
            bit_cnt_reg <= 3'd0;
            first_reg   <= 1'b0;
            data_reg    <= 8'd0;
            valid_reg   <= 1'b0;
            sot_reg     <= 1'b0;
            eot_reg     <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            sot_reg   <= 1'b0;
            eot_reg   <= ss_rise;
            if (ss_fall) begin
                bit_cnt_reg <= 3'd0;
                first_reg   <= 1'b1;
                tx_reg      <= 8'd0;
            end else if (ss_active) begin
                if (sclk_rise) begin
                    shift_reg   <= shift_in;
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        data_reg  <= shift_in;
                        valid_reg <= 1'b1;
                        sot_reg   <= first_reg;
                        first_reg <= 1'b0;
                        tx_reg    <= shift_in;
                    end
                end else if (sclk_fall && bit_cnt_reg != 3'd0) begin
                    tx_reg <= {tx_reg[6:0], 1'b0};
                end
            end
        end
    end

    assign miso  = tx_reg[7] & ss_active;
    assign data  = data_reg;
    assign valid = valid_reg;
    assign sot   = sot_reg;
    assign eot   = eot_reg;

endmodule

// File: rtl/spi_frame_loader.sv
// SPI command decoder for the display frame buffer. Decodes LOAD_ROW,
// SET_BRIGHT and COMMIT frames, packs pixel bytes into wdata words and
// flags malformed frames. Optional trailing row checksum is enabled by
// defining SPI_LOADER_CHECKSUM_EN.
module spi_frame_loader
    import display_pkg::*;
#(
    parameter int SEGMENTS = 1,
    parameter int CHANNELS = 3,
    parameter int BITWIDTH = 8,
    parameter int ROWS     = 8,
    parameter int COLUMNS  = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  sclk,
    input  logic                                  ss,
    input  logic                                  mosi,
    output logic                                  miso,
    input  logic                                  ready,
    output logic                                  wen,
    output logic [$clog2(ROWS)-1:0]               wrow,
    output logic [$clog2(COLUMNS)-1:0]            wcol,
    output logic [SEGMENTS*CHANNELS*BITWIDTH-1:0] wdata,
    output logic [7:0]                            brightness,
    output logic                                  loaded,
    output logic                                  frame_err
);

    localparam int GROUP = SEGMENTS * CHANNELS;
    localparam int DW    = GROUP * BITWIDTH;
    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLUMNS);
    localparam int GW    = (GROUP > 1) ? $clog2(GROUP) : 1;

    logic [7:0] byte_data;
    logic       byte_valid, byte_sot, byte_eot;

    spi_slave u_spi_slave (
        .clk   (clk),
        .rst   (rst),
        .sclk  (sclk),
        .ss    (ss),
        .mosi  (mosi),
        .miso  (miso),
        .data  (byte_data),
        .valid (byte_valid),
        .sot   (byte_sot),
        .eot   (byte_eot)
    );

    state_t          state_reg, state_next;
    logic [CW-1:0]   col_reg, col_next;
    logic [GW-1:0]   grp_reg, grp_next;
    logic [DW-1:0]   stage_reg, stage_next, stage_shift;
    logic            extra_reg, extra_next;
    logic            wen_reg, wen_next;
    logic [RW-1:0]   wrow_reg, wrow_next;
    logic [CW-1:0]   wcol_reg, wcol_next;
    logic [DW-1:0]   wdata_reg, wdata_next;
    logic [7:0]      bright_reg, bright_next;
    logic            loaded_reg, loaded_next;
    logic            err_reg, err_next;
`ifdef SPI_LOADER_CHECKSUM_EN
    logic [7:0]      csum_reg, csum_next;
    logic            dirty_reg, dirty_next;
`endif

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            col_reg    <= '0;
            grp_reg    <= '0;
            stage_reg  <= '0;
            extra_reg  <= 1'b0;
            wen_reg    <= 1'b0;
            wrow_reg   <= '0;
            wcol_reg   <= '0;
            wdata_reg  <= '0;
            bright_reg <= BRIGHT_RESET;
            loaded_reg <= 1'b0;
            err_reg    <= 1'b0;
`ifdef SPI_LOADER_CHECKSUM_EN
            csum_reg   <= 8'd0;
            dirty_reg  <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            col_reg    <= col_next;
            grp_reg    <= grp_next;
            stage_reg  <= stage_next;
            extra_reg  <= extra_next;
            wen_reg    <= wen_next;
            wrow_reg   <= wrow_next;
            wcol_reg   <= wcol_next;
            wdata_reg  <= wdata_next;
            bright_reg <= bright_next;
            loaded_reg <= loaded_next;
            err_reg    <= err_next;
`ifdef SPI_LOADER_CHECKSUM_EN
            csum_reg   <= csum_next;
            dirty_reg  <= dirty_next;
`endif
        end
    end

    // Next-state logic: the byte of this cycle is processed first, then an
    // eot in the same cycle terminates the frame based on where it ended up.
    always_comb begin
        state_next  = state_reg;
        col_next    = col_reg;
        grp_next    = grp_reg;
        stage_next  = stage_reg;
        extra_next  = extra_reg;
        wen_next    = 1'b0;
        wrow_next   = wrow_reg;
        wcol_next   = wcol_reg;
        wdata_next  = wdata_reg;
        bright_next = bright_reg;
        loaded_next = 1'b0;
        err_next    = 1'b0;
`ifdef SPI_LOADER_CHECKSUM_EN
        csum_next   = csum_reg;
        dirty_next  = dirty_reg;
`endif
        // New channel enters at the bottom so the group's first byte ends up
        // in the most-significant slot.
        stage_shift = DW'({stage_reg, byte_data[BITWIDTH-1:0]});

        if (byte_valid) begin
            case (state_reg)
                IDLE: begin
                    if (byte_sot) begin
                        col_next   = '0;
                        grp_next   = '0;
                        extra_next = 1'b0;
                        if (!ready) begin
                            state_next = DISCARD;
                        end else begin
                            case (byte_data)
                                OP_LOAD_ROW: state_next = ROW_ADDR;
                                OP_BRIGHT:   state_next = BRIGHT;
                                OP_COMMIT:   state_next = COMMIT;
                                default: begin
                                    state_next = DISCARD;
                                    err_next   = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                ROW_ADDR: begin
                    if (int'(byte_data) >= ROWS) begin
                        err_next   = 1'b1;
                        state_next = DISCARD;
                    end else begin
                        wrow_next  = byte_data[RW-1:0];
                        state_next = PIXELS;
                    end
`ifdef SPI_LOADER_CHECKSUM_EN
                    csum_next = byte_data;
`endif
                end
                PIXELS: begin
                    stage_next = stage_shift;
`ifdef SPI_LOADER_CHECKSUM_EN
                    csum_next = csum_reg ^ byte_data;
`endif
                    if (grp_reg == GW'(GROUP - 1)) begin
                        grp_next   = '0;
                        wen_next   = 1'b1;
                        wdata_next = stage_shift;
                        wcol_next  = col_reg;
                        if (col_reg == CW'(COLUMNS - 1)) begin
                            extra_next = 1'b1;
`ifdef SPI_LOADER_CHECKSUM_EN
                            state_next = CHECK;
`else
                            state_next = DISCARD;
`endif
                        end else begin
                            col_next = col_reg + CW'(1);
                        end
                    end else begin
                        grp_next = grp_reg + GW'(1);
                    end
                end
`ifdef SPI_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (byte_data != csum_reg) begin
                        err_next   = 1'b1;
                        dirty_next = 1'b1;
                    end
                    state_next = DISCARD;
                end
`endif
                BRIGHT: begin
                    bright_next = byte_data;
                    state_next  = DISCARD;
                end
                DISCARD: begin
                    // Only trailing bytes after a full row are reported, once.
                    if (extra_reg) begin
                        err_next   = 1'b1;
                        extra_next = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end

        if (byte_eot) begin
            case (state_next)
                ROW_ADDR, PIXELS: begin
                    err_next = 1'b1;
`ifdef SPI_LOADER_CHECKSUM_EN
                    dirty_next = 1'b1;
`endif
                end
                BRIGHT: err_next = 1'b1;
`ifdef SPI_LOADER_CHECKSUM_EN
                CHECK: begin
                    err_next   = 1'b1;
                    dirty_next = 1'b1;
                end
                COMMIT: begin
                    if (dirty_reg) dirty_next = 1'b0;
                    else           loaded_next = 1'b1;
                end
`else
                COMMIT: loaded_next = 1'b1;
`endif
                default: begin
                end
            endcase
            state_next = IDLE;
            extra_next = 1'b0;
        end
    end

    assign wen        = wen_reg;
    assign wrow       = wrow_reg;
    assign wcol       = wcol_reg;
    assign wdata      = wdata_reg;
    assign brightness = bright_reg;
    assign loaded     = loaded_reg;
    assign frame_err  = err_reg;

endmodule

// File: tb/tb_spi_frame_loader.sv
// Scoreboard bench for spi_frame_loader: each stimulus task pushes the
// write/error/commit events it expects; a monitor pops and compares them
// whenever the DUT raises wen, frame_err or loaded.
module tb_spi_frame_loader;

    localparam int HALF = 3;
    localparam logic [1:0] K_WR  = 2'd0;
    localparam logic [1:0] K_ERR = 2'd1;
    localparam logic [1:0] K_LD  = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [2:0]  row;
        logic [4:0]  col;
        logic [23:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst, sclk, ss, mosi, ready;
    logic        miso, wen, loaded, frame_err;
    logic [2:0]  wrow;
    logic [4:0]  wcol;
    logic [23:0] wdata;
    logic [7:0]  brightness;

    ev_t exp_q[$];
    int  n_compared = 0;
    int  n_mismatched = 0;
`ifdef SPI_LOADER_CHECKSUM_EN
    logic exp_dirty = 1'b0;
`endif

    spi_frame_loader dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .ss         (ss),
        .mosi       (mosi),
        .miso       (miso),
        .ready      (ready),
        .wen        (wen),
        .wrow       (wrow),
        .wcol       (wcol),
        .wdata      (wdata),
        .brightness (brightness),
        .loaded     (loaded),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded time limit, got no finish, required finish");
        $fatal(1);
    end

    function automatic logic [7:0] pix(input int pat, input int i);
        case (pat)
            0:       return 8'(i);
            1:       return 8'(i * 7 + 3);
            2:       return 8'(255 - i);
            default: return 8'(i) ^ 8'hA5;
        endcase
    endfunction

    function automatic void push_ev(input logic [1:0] k, input logic [2:0] r,
                                    input logic [4:0] c, input logic [23:0] d);
        ev_t e;
        e.kind = k; e.row = r; e.col = c; e.data = d;
        exp_q.push_back(e);
    endfunction

    // Monitor side of the scoreboard.
    task automatic check_ev(input logic [1:0] k);
        ev_t e;
        n_compared++;
        if (exp_q.size() == 0) begin
            n_mismatched++;
            $display("FAIL unexpected_event: got kind %0d (row %0d col %0d data %h), required none", k, wrow, wcol, wdata);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k) begin
                n_mismatched++;
                $display("FAIL event_kind: got kind %0d, required kind %0d", k, e.kind);
            end else if (k == K_WR && (wrow != e.row || wcol != e.col || wdata != e.data)) begin
                n_mismatched++;
                $display("FAIL write: got row %0d col %0d data %h, required row %0d col %0d data %h",
                         wrow, wcol, wdata, e.row, e.col, e.data);
            end else begin
                $display("ok event kind %0d row %0d col %0d data %h", k, wrow, wcol, wdata);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (wen)       check_ev(K_WR);
            if (frame_err) check_ev(K_ERR);
            if (loaded)    check_ev(K_LD);
        end
    end

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("ok %s = %h", name, act);
        end
    endtask

    task automatic check_drain(input string name);
        repeat (12) @(posedge clk);
        check_val(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic spi_begin();
        ss = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic spi_end();
        repeat (4) @(posedge clk);
        ss = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] v);
        for (int b = 7; b >= 0; b--) begin
            mosi = v[b];
            repeat (HALF) @(posedge clk);
            sclk = 1'b1;
            repeat (HALF) @(posedge clk);
            sclk = 1'b0;
        end
        repeat (2) @(posedge clk);
    endtask

    // LOAD_ROW frame with n pixel bytes; n < 96 makes a short frame.
    task automatic send_row(input logic [7:0] row, input int pat, input int n,
                            input int extra, input logic corrupt);
        logic [7:0] cs;
        cs = row;
        for (int g = 0; g < n / 3; g++)
            push_ev(K_WR, row[2:0], 5'(g), {pix(pat, 3*g), pix(pat, 3*g+1), pix(pat, 3*g+2)});
        if (n < 96) begin
            push_ev(K_ERR, 3'd0, 5'd0, 24'd0);
`ifdef SPI_LOADER_CHECKSUM_EN
            exp_dirty = 1'b1;
`endif
        end else begin
`ifdef SPI_LOADER_CHECKSUM_EN
            if (corrupt) begin
                push_ev(K_ERR, 3'd0, 5'd0, 24'd0);
                exp_dirty = 1'b1;
            end
`endif
            if (extra > 0) push_ev(K_ERR, 3'd0, 5'd0, 24'd0);
        end
        ready = 1'b1;
        spi_begin();
        spi_byte(8'hF0);
        spi_byte(row);
        for (int i = 0; i < n; i++) begin
            cs = cs ^ pix(pat, i);
            spi_byte(pix(pat, i));
        end
        if (n >= 96) begin
`ifdef SPI_LOADER_CHECKSUM_EN
            spi_byte(cs ^ {7'd0, corrupt});
`else
            if (corrupt) cs = ~cs;
`endif
            for (int e = 0; e < extra; e++) spi_byte(8'hEE);
        end
        spi_end();
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [7:0] arg,
                            input logic has_arg, input logic rdy);
        ready = rdy;
        spi_begin();
        spi_byte(op);
        if (has_arg) spi_byte(arg);
        spi_end();
        ready = 1'b1;
    endtask

    task automatic commit_expect_loaded();
`ifdef SPI_LOADER_CHECKSUM_EN
        if (exp_dirty) begin
            exp_dirty = 1'b0;
            send_cmd(8'h10, 8'h00, 1'b0, 1'b1);
            check_drain("commit_clears_dirty");
        end
`endif
        push_ev(K_LD, 3'd0, 5'd0, 24'd0);
        send_cmd(8'h10, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0; ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_val("reset_wen", 32'(wen), 0);
        check_val("reset_loaded", 32'(loaded), 0);
        check_val("reset_frame_err", 32'(frame_err), 0);
        check_val("reset_wrow_wcol", {24'd0, wrow, wcol}, 0);
        check_val("reset_wdata", 32'(wdata), 0);
        check_val("reset_brightness", 32'(brightness), 32'hFF);
        @(posedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);

        // Full row 3 of bytes 00..5F: first word 000102, last 5D5E5F.
        send_row(8'h03, 0, 96, 0, 1'b0);
        check_drain("row3_full");

        // Out-of-range row index.
        push_ev(K_ERR, 3'd0, 5'd0, 24'd0);
        spi_begin();
        spi_byte(8'hF0);
        spi_byte(8'h09);
        spi_end();
        check_drain("bad_row_index");

        // Unknown opcode.
        push_ev(K_ERR, 3'd0, 5'd0, 24'd0);
        send_cmd(8'h55, 8'h01, 1'b1, 1'b1);
        check_drain("unknown_opcode");

        // Short frame: 7 pixel bytes give two writes and one error.
        send_row(8'h00, 1, 7, 0, 1'b0);
        check_drain("short_frame");
        send_row(8'h05, 1, 96, 0, 1'b0);
        check_drain("row5_after_short");

        // Trailing bytes after a full row report one error only.
        send_row(8'h07, 2, 96, 2, 1'b0);
        check_drain("row7_extra_bytes");

        // Brightness, then COMMIT not ready, then COMMIT ready.
        send_cmd(8'h20, 8'h40, 1'b1, 1'b1);
        check_val("brightness_set", 32'(brightness), 32'h40);
        send_cmd(8'h10, 8'h00, 1'b0, 1'b0);
        check_drain("commit_not_ready");
        commit_expect_loaded();
        check_drain("commit_ready");

        // Reset after 10 pixel bytes: three writes, then nothing.
        for (int g = 0; g < 3; g++)
            push_ev(K_WR, 3'd2, 5'(g), {pix(3, 3*g), pix(3, 3*g+1), pix(3, 3*g+2)});
        spi_begin();
        spi_byte(8'hF0);
        spi_byte(8'h02);
        for (int i = 0; i < 10; i++) spi_byte(pix(3, i));
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("midreset_wen", 32'(wen), 0);
        check_val("midreset_wrow_wcol", {24'd0, wrow, wcol}, 0);
        check_val("midreset_wdata", 32'(wdata), 0);
        check_val("midreset_brightness", 32'(brightness), 32'hFF);
        @(posedge clk);
        rst = 1'b0;
`ifdef SPI_LOADER_CHECKSUM_EN
        exp_dirty = 1'b0;
`endif
        for (int i = 10; i < 12; i++) spi_byte(pix(3, i));
        spi_end();
        check_drain("midreset_no_writes");
        send_row(8'h06, 3, 96, 0, 1'b0);
        check_drain("row6_after_reset");

`ifdef SPI_LOADER_CHECKSUM_EN
        // Bad checksum: error, first COMMIT swallowed, second COMMIT loads.
        send_row(8'h01, 0, 96, 0, 1'b1);
        check_drain("bad_checksum_row");
        exp_dirty = 1'b0;
        send_cmd(8'h10, 8'h00, 1'b0, 1'b1);
        check_drain("dirty_commit_no_loaded");
        push_ev(K_LD, 3'd0, 5'd0, 24'd0);
        send_cmd(8'h10, 8'h00, 1'b0, 1'b1);
        check_drain("second_commit_loaded");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
